// File: rtl/random_access_memory.sv
// 16x8 program/data RAM: run-mode writes from the CPU bus, manual-mode writes
// from front-panel switches on a synchronized, edge-detected push-button.
module random_access_memory #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_from_bus,
  input  logic                  manual_mode,
  input  logic                  manual_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] program_switches,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d [DEPTH];
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   history_q;
  logic                   history_d;
  logic                   write_pulse;
  logic                   write_en;
  logic [DATA_WIDTH-1:0]  write_data;

  // The synchronizer runs in both modes so a press held across a mode
  // switch has already been consumed by the edge detector.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], manual_read};
    history_d   = sync_q[SYNC_STAGES-1];
    write_pulse = sync_q[SYNC_STAGES-1] & ~history_q;
  end

  always_comb begin
    write_en   = manual_mode ? write_pulse : read_from_bus;
    write_data = manual_mode ? program_switches : bus_in;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (write_en) begin
      mem_d[address] = write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      history_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync_q    <= sync_d;
      history_q <= history_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus_out = mem_q[address];

endmodule

// File: tb/tb_random_access_memory.sv
// Self-checking bench for random_access_memory: vector table, hand-written
// button/reset sequences and randomized traffic against a reference model.
module tb_random_access_memory;

  logic       clk;
  logic       rst_n;
  logic       read_from_bus;
  logic       manual_mode;
  logic       manual_read;
  logic [3:0] address;
  logic [7:0] program_switches;
  logic [7:0] bus_in;
  logic [7:0] bus_out;

  random_access_memory #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .read_from_bus   (read_from_bus),
    .manual_mode     (manual_mode),
    .manual_read     (manual_read),
    .address         (address),
    .program_switches(program_switches),
    .bus_in          (bus_in),
    .bus_out         (bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: memory contents plus the button level seen at every clock edge.
  // A manual write commits at edge k when the button was seen high at edge k-2
  // and low at edge k-3 (edges under reset count as low).
  logic [7:0] model_mem [16];
  bit         btn_seen [$];

  typedef struct {
    bit         we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    if (!rst_n) begin
      btn_seen.push_back(1'b0);
    end else begin
      btn_seen.push_back(manual_read);
      if (manual_mode) begin
        if (btn_seen[$-2] && !btn_seen[$-3]) model_mem[address] = program_switches;
      end else if (read_from_bus) begin
        model_mem[address] = bus_in;
      end
    end
    if (btn_seen.size() > 8) void'(btn_seen.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      address = 4'(i);
      #1;
      check(name, bus_out, 8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; read_from_bus = 1'b0; manual_mode = 1'b0; manual_read = 1'b0;
    address = 4'h0; program_switches = 8'h00; bus_in = 8'h00;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) btn_seen.push_back(1'b0);

    // Reset state
    for (int i = 0; i < 3; i++) step();
    sweep_zero("reset_init");
    #2 rst_n = 1'b1;
    step();

    // Run-mode vector table
    vecs.push_back('{1'b1, 4'h3, 8'hA5, 8'hA5});
    vecs.push_back('{1'b0, 4'h3, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 4'h4, 8'h00, 8'h00});
    for (int i = 0; i < 16; i++) vecs.push_back('{1'b1, 4'(i), 8'(i * 8'h11), 8'(i * 8'h11)});
    for (int i = 0; i < 16; i++) vecs.push_back('{1'b0, 4'(i), 8'h00, 8'(i * 8'h11)});
    vecs.push_back('{1'b1, 4'hF, 8'h12, 8'h12});
    vecs.push_back('{1'b1, 4'hF, 8'hFF, 8'hFF});
    vecs.push_back('{1'b0, 4'hF, 8'h00, 8'hFF});
    foreach (vecs[i]) begin
      manual_mode   = 1'b0;
      address       = vecs[i].addr;
      bus_in        = vecs[i].din;
      read_from_bus = vecs[i].we;
      if (vecs[i].we) step();
      else #1;
      check($sformatf("vec%0d", i), bus_out, vecs[i].exp);
    end
    read_from_bus = 1'b0;

    // Manual write latency and one-write-per-press
    manual_mode = 1'b1; address = 4'h7; program_switches = 8'h3C;
    step();
    manual_read = 1'b1;
    step(); check("man_lat_n", bus_out, 8'h77);
    step(); check("man_lat_n1", bus_out, 8'h77);
    step(); check("man_lat_n2", bus_out, 8'h3C);
    program_switches = 8'h99;
    for (int i = 0; i < 7; i++) step();
    check("man_hold", bus_out, 8'h3C);
    manual_read = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("man_release", bus_out, 8'h3C);

    // Isolation: bus ignored in manual mode
    address = 4'h9; read_from_bus = 1'b1; bus_in = 8'hFF;
    step(); step();
    check("iso_bus", bus_out, 8'h99);
    read_from_bus = 1'b0;

    // Isolation: button ignored in run mode, and a press held across mode switch
    manual_mode = 1'b0; address = 4'h5; program_switches = 8'h55;
    manual_read = 1'b1;
    for (int i = 0; i < 4; i++) step();
    manual_read = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("iso_btn", bus_out, 8'h55);
    address = 4'h6; program_switches = 8'hE1;
    manual_read = 1'b1;
    for (int i = 0; i < 5; i++) step();
    manual_mode = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("held_mode_switch", bus_out, 8'h66);
    manual_read = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Async reset mid-press
    address = 4'hA; program_switches = 8'h5A; manual_read = 1'b1;
    step();
    #2 assert_reset();
    #1 check("rst_async", bus_out, 8'h00);
    read_from_bus = 1'b1; bus_in = 8'hC3;
    for (int i = 0; i < 4; i++) step();
    sweep_zero("rst_sweep");
    address = 4'hA; read_from_bus = 1'b0;
    #1 rst_n = 1'b1;
    step(); check("rst_rel_1", bus_out, 8'h00);
    step(); check("rst_rel_2", bus_out, 8'h00);
    step(); check("rst_rel_3", bus_out, 8'h5A);
    program_switches = 8'h11;
    for (int i = 0; i < 5; i++) step();
    check("rst_rel_once", bus_out, 8'h5A);
    manual_read = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) manual_mode = ~manual_mode;
      if ($urandom_range(0, 3) == 0) manual_read = ~manual_read;
      read_from_bus    = 1'($urandom_range(0, 1));
      address          = 4'($urandom);
      program_switches = 8'($urandom);
      bus_in           = 8'($urandom);
      step();
      check("rand_post", bus_out, model_mem[address]);
      address = 4'($urandom);
      #1 check("rand_read", bus_out, model_mem[address]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/random_access_memory.md
Name: random_access_memory

Overview:
16 x 8 program/data RAM for the 8-bit CPU, addressed by the 4-bit memory address register. In run mode it captures a byte from the shared CPU bus. In manual (programming) mode it captures a byte from front-panel switches when a push-button is pressed. Read data is continuously presented on bus_out; bus arbitration and output enabling are handled at top level.

Parameters:
DATA_WIDTH, 8, word width of memory, bus_in, bus_out, program_switches
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH (16)
SYNC_STAGES, 2, flops in manual_read synchronizer (minimum 2)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
read_from_bus  input  1  run-mode write enable: capture bus_in into mem[address]
manual_mode  input  1  1 = programming mode (switch writes), 0 = run mode (bus writes)
manual_read  input  1  asynchronous push-button; rising edge commits program_switches in manual mode
address  input  ADDR_WIDTH  read/write address
program_switches  input  DATA_WIDTH  manual write data
bus_in  input  DATA_WIDTH  CPU bus data
bus_out  output  DATA_WIDTH  mem[address], combinational

Behaviour:
- Storage: 2**ADDR_WIDTH words of DATA_WIDTH bits, plus manual_read synchronizer/edge-detect flops.
- Reset (rst_n=0, asynchronous): all memory words and synchronizer flops cleared to 0. bus_out = 0 during and immediately after reset. Writes blocked while rst_n=0.
- Read: bus_out = mem[address], purely combinational. Zero-cycle latency from address change. A write becomes visible on bus_out right after the committing clock edge.
- Run-mode write (manual_mode=0): at rising clk with read_from_bus=1, mem[address] <= bus_in. Single-cycle, no handshake. read_from_bus held high writes every cycle (last value wins).
- Manual-mode write (manual_mode=1):
  - manual_read passes through SYNC_STAGES flops, then one history flop.
  - write_pulse = last_sync & ~history.
  - When manual_mode=1 and write_pulse=1, mem[address] <= program_switches at that edge.
  - Latency with defaults: manual_read high before edge N -> write committed at edge N+2.
  - Exactly one write per button press regardless of press duration.
  - Release produces no write.
- read_from_bus is ignored while manual_mode=1.
- manual_read edges are ignored while manual_mode=0. Synchronizer keeps running in both modes, so a button held across a mode switch does not write.
- Mode switch mid-press: write happens only if manual_mode=1 on the pulse cycle.
- address and data are sampled at the committing edge. Address wraps naturally within ADDR_WIDTH; no out-of-range accesses exist.
- No X propagation: every memory location is defined from reset.

Test Plan:
- Reset: assert rst_n=0 mid-run after writes; sweep address 0..15 -> bus_out = 0x00 everywhere.
- Run write/read: manual_mode=0, read_from_bus=1, address=0x3, bus_in=0xA5, one edge; then read_from_bus=0, address=0x3 -> bus_out=0xA5; address=0x4 -> 0x00.
- Fill/verify: write mem[i]=i*0x11 for i=0..15 via bus, read back all 16 -> exact values, incl. address 0xF = 0xFF.
- Manual write: manual_mode=1, address=0x7, program_switches=0x3C, raise manual_read for 10 cycles -> mem[7]=0x3C exactly 2 edges after first sampling. Change switches to 0x99 while held -> mem[7] stays 0x3C.
- Isolation: manual_mode=1, read_from_bus=1, bus_in=0xFF -> no write. manual_mode=0, pulse manual_read with switches=0x55 -> no write.
- Async reset mid-press: rst_n low while manual_read high -> memory cleared; after release of reset with button still held, the next rising edge of the synchronized button produces one write.
